// File: rtl/encoder_16_to_4.sv
// 16-to-4 priority encoder (bit 15 highest) with a registered copy.
// Optional one-hot checker enabled by defining ENC16_ONEHOT_CHECK_EN.
module encoder_16_to_4 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] bits,
    output logic [3:0]  number,
    output logic        valid,
    output logic [3:0]  number_q,
    output logic        valid_q,
    output logic        multi_err,
    output logic        err_sticky
);

    // Ascending scan: the last set bit seen is the highest index.
    always_comb begin
        number = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (bits[i]) begin
                number = 4'(i);
            end
        end
    end

    assign valid = |bits;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            number_q <= 4'd0;
            valid_q  <= 1'b0;
        end else begin
            number_q <= number;
            valid_q  <= valid;
        end
    end

`ifdef ENC16_ONEHOT_CHECK_EN
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi_err = |(bits & (bits - 16'd1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sticky <= 1'b0;
        end else if (multi_err) begin
            err_sticky <= 1'b1;
        end
    end
`else
    assign multi_err  = 1'b0;
    assign err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_encoder_16_to_4.sv
// Scoreboard bench for encoder_16_to_4; expected register values are
// queued when bits is driven and popped one clock edge later.
module tb_encoder_16_to_4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] bits = 16'h0000;
    logic [3:0]  number;
    logic        valid;
    logic [3:0]  number_q;
    logic        valid_q;
    logic        multi_err;
    logic        err_sticky;

    int checks = 0;
    int errors = 0;

`ifdef ENC16_ONEHOT_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct {
        logic [3:0] num;
        logic       vld;
    } exp_t;

    exp_t sb[$];
    logic m_sticky = 1'b0;

    encoder_16_to_4 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bits       (bits),
        .number     (number),
        .valid      (valid),
        .number_q   (number_q),
        .valid_q    (valid_q),
        .multi_err  (multi_err),
        .err_sticky (err_sticky)
    );

    always #5 clk = ~clk;

    // Reference: scan down from bit 15, first hit wins.
    function automatic logic [3:0] ref_num(input logic [15:0] b);
        for (int i = 15; i >= 0; i--) begin
            if (b[i]) return 4'(i);
        end
        return 4'd0;
    endfunction

    function automatic logic ref_err(input logic [15:0] b);
        return CHK && ($countones(b) >= 2);
    endfunction

    task automatic push_exp(input logic [15:0] b);
        exp_t e;
        e.num = ref_num(b);
        e.vld = (b != 16'h0000);
        sb.push_back(e);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bits  = 16'h0000;
        #1;
        checks++;
        if (number_q !== 4'd0 || valid_q !== 1'b0 || err_sticky !== 1'b0) begin
            errors++;
            $display("FAIL reset: number_q=%0d valid_q=%b err_sticky=%b, want 0 0 0",
                     number_q, valid_q, err_sticky);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_sticky = 1'b0;
    endtask

    task automatic test_zero;
        @(negedge clk);
        bits = 16'h0000;
        #10;
        checks++;
        if (number !== 4'd0 || valid !== 1'b0 || multi_err !== 1'b0) begin
            errors++;
            $display("FAIL zero: number=%0d valid=%b multi_err=%b, want 0 0 0",
                     number, valid, multi_err);
        end
    endtask

    task automatic test_walk;
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            bits = 16'h0001 << i;
            push_exp(bits);
            #1;
            checks++;
            if (number !== 4'(i) || valid !== 1'b1 || multi_err !== 1'b0) begin
                errors++;
                $display("FAIL walk[%0d]: number=%0d valid=%b multi_err=%b, want %0d 1 0",
                         i, number, valid, multi_err, i);
            end
            @(posedge clk);
            #1;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL walk_q[%0d]: scoreboard empty", i);
            end else begin
                e = sb.pop_front();
                if (number_q !== e.num || valid_q !== e.vld) begin
                    errors++;
                    $display("FAIL walk_q[%0d]: number_q=%0d valid_q=%b, want %0d %b",
                             i, number_q, valid_q, e.num, e.vld);
                end
            end
        end
    endtask

    task automatic test_async_reset;
        exp_t e;
        @(negedge clk);
        bits = 16'h0400;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (number_q !== 4'd0 || valid_q !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: number_q=%0d valid_q=%b, want 0 0",
                     number_q, valid_q);
        end
        @(posedge clk);
        #1;
        checks++;
        if (number_q !== 4'd0 || valid_q !== 1'b0 || number !== 4'd10 || valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_hold: number_q=%0d valid_q=%b number=%0d valid=%b, want 0 0 10 1",
                     number_q, valid_q, number, valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_sticky = 1'b0;
        push_exp(bits);
        @(posedge clk);
        #1;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL reset_release: scoreboard empty");
        end else begin
            e = sb.pop_front();
            if (number_q !== e.num || valid_q !== e.vld || e.num !== 4'd10) begin
                errors++;
                $display("FAIL reset_release: number_q=%0d valid_q=%b, want 10 1",
                         number_q, valid_q);
            end
        end
    endtask

    task automatic test_between_edges;
        @(negedge clk);
        bits = 16'h0001;
        @(posedge clk);
        #1;
        checks++;
        if (number_q !== 4'd0 || valid_q !== 1'b1) begin
            errors++;
            $display("FAIL between_pre: number_q=%0d valid_q=%b, want 0 1",
                     number_q, valid_q);
        end
        #2;
        bits = 16'h0020;
        #1;
        checks++;
        if (number !== 4'd5 || number_q !== 4'd0) begin
            errors++;
            $display("FAIL between_mid: number=%0d number_q=%0d, want 5 0",
                     number, number_q);
        end
        @(posedge clk);
        #1;
        checks++;
        if (number_q !== 4'd5 || valid_q !== 1'b1) begin
            errors++;
            $display("FAIL between_post: number_q=%0d valid_q=%b, want 5 1",
                     number_q, valid_q);
        end
    endtask

    task automatic test_multi_hot;
        @(negedge clk);
        bits = 16'h0006;
        #1;
        checks++;
        if (number !== 4'd2 || multi_err !== CHK || err_sticky !== 1'b0) begin
            errors++;
            $display("FAIL multi_0006: number=%0d multi_err=%b err_sticky=%b, want 2 %b 0",
                     number, multi_err, err_sticky, CHK);
        end
        // Reset so the sticky check below is driven only by 16'h8001.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bits  = 16'h8001;
        #1;
        checks++;
        if (number !== 4'd15 || valid !== 1'b1 || multi_err !== CHK || err_sticky !== 1'b0) begin
            errors++;
            $display("FAIL multi_8001: number=%0d valid=%b multi_err=%b err_sticky=%b, want 15 1 %b 0",
                     number, valid, multi_err, err_sticky, CHK);
        end
        @(posedge clk);
        #1;
        checks++;
        if (err_sticky !== CHK || number_q !== 4'd15) begin
            errors++;
            $display("FAIL sticky_set: err_sticky=%b number_q=%0d, want %b 15",
                     err_sticky, number_q, CHK);
        end
        @(negedge clk);
        bits = 16'h0002;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (err_sticky !== CHK || multi_err !== 1'b0 || number_q !== 4'd1) begin
            errors++;
            $display("FAIL sticky_hold: err_sticky=%b multi_err=%b number_q=%0d, want %b 0 1",
                     err_sticky, multi_err, number_q, CHK);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (err_sticky !== 1'b0) begin
            errors++;
            $display("FAIL sticky_clear: err_sticky=%b, want 0", err_sticky);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_sticky = 1'b0;
    endtask

    task automatic test_back_to_back;
        exp_t        e;
        logic [15:0] v;
        localparam int N = 40;
        @(negedge clk);
        v = ($urandom_range(0, 1) == 1) ? (16'h0001 << $urandom_range(0, 15))
                                        : 16'($urandom);
        bits = v;
        push_exp(v);
        for (int k = 1; k <= N; k++) begin
            @(posedge clk);
            m_sticky = m_sticky | ref_err(bits);
            #1;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL b2b[%0d]: scoreboard empty", k);
            end else begin
                e = sb.pop_front();
                if (number_q !== e.num || valid_q !== e.vld || err_sticky !== m_sticky) begin
                    errors++;
                    $display("FAIL b2b[%0d]: number_q=%0d valid_q=%b err_sticky=%b, want %0d %b %b",
                             k, number_q, valid_q, err_sticky, e.num, e.vld, m_sticky);
                end
            end
            @(negedge clk);
            if (k < N) begin
                case (k % 4)
                    0: v = 16'h0000;
                    1: v = 16'h0001 << $urandom_range(0, 15);
                    default: v = 16'($urandom);
                endcase
                bits = v;
                push_exp(v);
                #1;
                checks++;
                if (number !== ref_num(v) || valid !== (v != 16'h0000) || multi_err !== ref_err(v)) begin
                    errors++;
                    $display("FAIL b2b_comb[%0d]: bits=%h number=%0d valid=%b multi_err=%b",
                             k, v, number, valid, multi_err);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_walk();
        test_async_reset();
        test_between_edges();
        test_multi_hot();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
